iot_teletype: RTL and testbench

Console teletype responder on the IOT side of the main bus: decodes IOT instructions issued by the PDP-8 CPU for keyboard (device 03) and printer (device 04), and returns skip, AC-clear and read-data responses. The CPU presents IOT transfers and `dataout`, and consumes `datain`/skip; this block is the device end of that exchange. It also buffers keyboard characters from the external source and paces printer output with a busy timer.

---
 rtl/iot_teletype_pkg.sv | 29 ++
 rtl/tty_kbd_fifo.sv | 59 +++++
 rtl/iot_teletype.sv | 174 +++++++++++++++++
 tb/tb_iot_teletype.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iot_teletype_pkg.sv
// Shared definitions for the PDP-8 console teletype IOT responder:
// device codes, IOT function codes and the printer state encoding.
package iot_teletype_pkg;

    localparam logic [5:0] KBD_DEV_CODE = 6'o03;
    localparam logic [5:0] TTY_DEV_CODE = 6'o04;

    typedef enum logic [2:0] {
        KCF = 3'd0,
        KSF = 3'd1,
        KCC = 3'd2,
        KRS = 3'd4,
        KRB = 3'd6
    } kbd_func_e;

    typedef enum logic [2:0] {
        TFL = 3'd0,
        TSF = 3'd1,
        TCF = 3'd2,
        TPC = 3'd4,
        TLS = 3'd6
    } tty_func_e;

    typedef enum logic {
        PRN_IDLE = 1'b0,
        PRN_BUSY = 1'b1
    } prn_state_e;

endpackage

// File: rtl/tty_kbd_fifo.sv
// Synchronous FIFO for buffered keyboard characters; a pop and a push in the
// same cycle are both honoured even when full.
module tty_kbd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_head    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
            end
            if (w_do_push) begin
                r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iot_teletype.sv
// Console teletype IOT responder (keyboard + printer) for the PDP-8 bus.
// Define TTY_KBD_FIFO_EN to replace the single keyboard buffer with a FIFO.
module iot_teletype
    import iot_teletype_pkg::*;
#(
    parameter logic [5:0]  KBD_DEV        = KBD_DEV_CODE,
    parameter logic [5:0]  TTY_DEV        = TTY_DEV_CODE,
    parameter int unsigned PRINT_CYCLES   = 10,
    parameter int unsigned KBD_FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       iot_valid,
    input  logic [5:0] iot_device,
    input  logic [2:0] iot_func,
    input  logic [7:0] dataout,
    output logic [7:0] datain,
    output logic       datain_valid,
    output logic       ac_clear,
    output logic       skip,
    input  logic [7:0] kbd_char,
    input  logic       kbd_strobe,
    output logic [7:0] tty_char,
    output logic       tty_strobe,
    output logic       kbd_overrun
);

    localparam int unsigned CNT_W = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;

    if (PRINT_CYCLES < 1 || KBD_FIFO_DEPTH < 1 ||
        (KBD_FIFO_DEPTH & (KBD_FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("iot_teletype: PRINT_CYCLES must be >=1 and KBD_FIFO_DEPTH a power of 2");
    end

    logic w_kbd_hit, w_tty_hit;
    logic w_kbd_clr, w_kbd_ksf, w_kbd_acc, w_kbd_read;
    logic w_tty_set, w_tty_tsf, w_tty_clr, w_tty_start;
    logic w_kbd_flag, w_overrun_evt, w_prn_done;
    logic [7:0] w_kbd_head;

    assign w_kbd_hit   = iot_valid && (iot_device == KBD_DEV);
    assign w_tty_hit   = iot_valid && (iot_device == TTY_DEV);
    assign w_kbd_clr   = w_kbd_hit && (iot_func == KCF || iot_func == KCC || iot_func == KRB);
    assign w_kbd_ksf   = w_kbd_hit && (iot_func == KSF);
    assign w_kbd_acc   = w_kbd_hit && (iot_func == KCC || iot_func == KRB);
    assign w_kbd_read  = w_kbd_hit && (iot_func == KRS || iot_func == KRB);
    assign w_tty_set   = w_tty_hit && (iot_func == TFL);
    assign w_tty_tsf   = w_tty_hit && (iot_func == TSF);
    assign w_tty_clr   = w_tty_hit && (iot_func == TCF || iot_func == TLS);
    assign w_tty_start = w_tty_hit && (iot_func == TPC || iot_func == TLS);

`ifdef TTY_KBD_FIFO_EN
    logic       w_fifo_empty, w_fifo_full;
    logic [7:0] w_fifo_head;

    tty_kbd_fifo #(
        .DEPTH (KBD_FIFO_DEPTH),
        .WIDTH (8)
    ) u_kbd_fifo (
        .i_clk   (clock),
        .i_rst_n (resetN),
        .i_push  (kbd_strobe),
        .i_data  (kbd_char),
        .i_pop   (w_kbd_clr),
        .o_head  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign w_kbd_flag    = !w_fifo_empty;
    assign w_kbd_head    = w_fifo_empty ? '0 : w_fifo_head;
    // A pop on a full FIFO frees the slot this push needs, so only a bare full loses data.
    assign w_overrun_evt = kbd_strobe && w_fifo_full && !w_kbd_clr;
`else
    logic       r_kbd_flag;
    logic [7:0] r_kbd_buf;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_kbd_flag <= 1'b0;
            r_kbd_buf  <= '0;
        end else if (kbd_strobe) begin
            r_kbd_flag <= 1'b1;
            r_kbd_buf  <= kbd_char;
        end else if (w_kbd_clr) begin
            r_kbd_flag <= 1'b0;
        end
    end

    assign w_kbd_flag    = r_kbd_flag;
    assign w_kbd_head    = r_kbd_buf;
    // The old character is not lost if the CPU consumes it in the same cycle.
    assign w_overrun_evt = kbd_strobe && r_kbd_flag && !w_kbd_clr;
`endif

    logic       r_tty_flag;
    logic       r_overrun;
    logic       r_skip, r_ac_clear, r_datain_valid;
    logic [7:0] r_datain;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_skip         <= 1'b0;
            r_ac_clear     <= 1'b0;
            r_datain_valid <= 1'b0;
            r_datain       <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_skip         <= (w_kbd_ksf && w_kbd_flag) || (w_tty_tsf && r_tty_flag);
            r_ac_clear     <= w_kbd_acc;
            r_datain_valid <= w_kbd_read;
            r_datain       <= w_kbd_read ? w_kbd_head : '0;
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end
        end
    end

    prn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tty_char;
    logic             r_tty_strobe;

    assign w_prn_done = (r_state == PRN_BUSY) && (r_cnt == '0);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state      <= PRN_IDLE;
            r_cnt        <= '0;
            r_tty_char   <= '0;
            r_tty_strobe <= 1'b0;
        end else begin
            r_tty_strobe <= 1'b0;
            case (r_state)
                PRN_IDLE: begin
                    if (w_tty_start) begin
                        r_tty_char <= dataout;
                        r_cnt      <= CNT_W'(PRINT_CYCLES - 1);
                        r_state    <= PRN_BUSY;
                    end
                end
                PRN_BUSY: begin
                    if (r_cnt == '0) begin
                        r_tty_strobe <= 1'b1;
                        r_state      <= PRN_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= PRN_IDLE;
            endcase
        end
    end

    // Print completion outranks a TCF/TLS clear arriving on the same edge.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_tty_flag <= 1'b0;
        end else if (w_prn_done || w_tty_set) begin
            r_tty_flag <= 1'b1;
        end else if (w_tty_clr) begin
            r_tty_flag <= 1'b0;
        end
    end

    assign skip         = r_skip;
    assign ac_clear     = r_ac_clear;
    assign datain_valid = r_datain_valid;
    assign datain       = r_datain;
    assign kbd_overrun  = r_overrun;
    assign tty_char     = r_tty_char;
    assign tty_strobe   = r_tty_strobe;

endmodule

// File: tb/tb_iot_teletype.sv
// Scoreboard bench for iot_teletype: directed test-plan sequences followed by
// randomized IOT traffic, checked against a queue/cycle-based reference model.
module tb_iot_teletype;

    localparam int PC    = 10;
    localparam int DEPTH = 4;
    localparam logic [5:0] KDEV = 6'o03;
    localparam logic [5:0] TDEV = 6'o04;
    localparam logic [2:0] F_KCF = 3'd0, F_KSF = 3'd1, F_KCC = 3'd2, F_KRS = 3'd4, F_KRB = 3'd6;
    localparam logic [2:0] F_TFL = 3'd0, F_TSF = 3'd1, F_TCF = 3'd2, F_TPC = 3'd4, F_TLS = 3'd6;

    logic       clock = 1'b0;
    logic       resetN;
    logic       iot_valid;
    logic [5:0] iot_device;
    logic [2:0] iot_func;
    logic [7:0] dataout;
    logic [7:0] datain;
    logic       datain_valid;
    logic       ac_clear;
    logic       skip;
    logic [7:0] kbd_char;
    logic       kbd_strobe;
    logic [7:0] tty_char;
    logic       tty_strobe;
    logic       kbd_overrun;

    iot_teletype #(
        .KBD_DEV        (KDEV),
        .TTY_DEV        (TDEV),
        .PRINT_CYCLES   (PC),
        .KBD_FIFO_DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .iot_valid    (iot_valid),
        .iot_device   (iot_device),
        .iot_func     (iot_func),
        .dataout      (dataout),
        .datain       (datain),
        .datain_valid (datain_valid),
        .ac_clear     (ac_clear),
        .skip         (skip),
        .kbd_char     (kbd_char),
        .kbd_strobe   (kbd_strobe),
        .tty_char     (tty_char),
        .tty_strobe   (tty_strobe),
        .kbd_overrun  (kbd_overrun)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    typedef struct { int edge_n; logic [10:0] vec; } resp_t;
    typedef struct { int edge_n; logic [7:0] ch; } prn_t;
    resp_t rq[$];
    prn_t  pq[$];

    // Reference model state
    logic [7:0] m_kq[$];
    logic       m_kflag;
    logic [7:0] m_kbuf;
    logic       m_ovr;
    logic       m_tflag;
    int         m_done;

    function automatic void model_reset();
        m_kq.delete();
        m_kflag = 1'b0;
        m_kbuf  = '0;
        m_ovr   = 1'b0;
        m_tflag = 1'b0;
        m_done  = -1;
        rq.delete();
        pq.delete();
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Applied once per sampling edge, using the inputs held at that edge.
    function automatic void model_edge();
        logic       kh, th, kclr, have;
        logic       sk, ac, dv;
        logic [7:0] d, head;
        logic       busy;
        kh = iot_valid && (iot_device == KDEV);
        th = iot_valid && (iot_device == TDEV);
        kclr = kh && (iot_func == F_KCF || iot_func == F_KCC || iot_func == F_KRB);
        sk = 1'b0; ac = 1'b0; dv = 1'b0; d = '0;
`ifdef TTY_KBD_FIFO_EN
        have = (m_kq.size() > 0);
        head = have ? m_kq[0] : 8'h00;
`else
        have = m_kflag;
        head = m_kbuf;
`endif
        if (kh) begin
            case (iot_func)
                F_KSF: sk = have;
                F_KCC: ac = 1'b1;
                F_KRS: begin dv = 1'b1; d = head; end
                F_KRB: begin ac = 1'b1; dv = 1'b1; d = head; end
                default: ;
            endcase
        end
        if (th && iot_func == F_TSF) sk = m_tflag;
        if ({sk, ac, dv, d} != 11'd0) rq.push_back('{n, {sk, ac, dv, d}});

`ifdef TTY_KBD_FIFO_EN
        if (kclr && m_kq.size() > 0) void'(m_kq.pop_front());
        if (kbd_strobe) begin
            if (m_kq.size() < DEPTH) m_kq.push_back(kbd_char);
            else m_ovr = 1'b1;
        end
`else
        if (kbd_strobe) begin
            if (m_kflag && !kclr) m_ovr = 1'b1;
            m_kbuf  = kbd_char;
            m_kflag = 1'b1;
        end else if (kclr) begin
            m_kflag = 1'b0;
        end
`endif

        busy = (m_done >= n);
        if (th && iot_func == F_TFL) m_tflag = 1'b1;
        if (th && (iot_func == F_TCF || iot_func == F_TLS)) m_tflag = 1'b0;
        if (th && (iot_func == F_TPC || iot_func == F_TLS) && !busy) begin
            m_done = n + PC;
            pq.push_back('{n + PC, dataout});
        end
        if (n == m_done) m_tflag = 1'b1;
    endfunction

    task automatic step(input logic iv, input logic [5:0] dev, input logic [2:0] fn,
                        input logic [7:0] dout, input logic ks, input logic [7:0] kc);
        iot_valid  = iv;
        iot_device = dev;
        iot_func   = fn;
        dataout    = dout;
        kbd_strobe = ks;
        kbd_char   = kc;
        @(posedge clock);
        n++;
        model_edge();
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic kio(input logic [2:0] fn);
        step(1'b1, KDEV, fn, '0, 1'b0, '0);
    endtask

    task automatic tio(input logic [2:0] fn, input logic [7:0] dout);
        step(1'b1, TDEV, fn, dout, 1'b0, '0);
    endtask

    task automatic kstrobe(input logic [7:0] c);
        step(1'b0, '0, '0, '0, 1'b1, c);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or a print.
    always @(negedge clock) begin : monitor
        logic [10:0] act;
        resp_t e;
        prn_t  p;
        act = {skip, ac_clear, datain_valid, datain};
        if (act != 11'd0) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got %h at edge %0d expected none", act, n);
            end else begin
                e = rq.pop_front();
                if (e.edge_n != n || e.vec != act) begin
                    failures++;
                    $display("FAIL resp: got %h at edge %0d expected %h at edge %0d",
                             act, n, e.vec, e.edge_n);
                end
            end
        end else if (rq.size() > 0 && rq[0].edge_n <= n) begin
            e = rq.pop_front();
            checks++;
            failures++;
            $display("FAIL resp_missing: got none at edge %0d expected %h", n, e.vec);
        end

        if (tty_strobe) begin
            checks++;
            if (pq.size() == 0) begin
                failures++;
                $display("FAIL tty_unexpected: got strobe char %h at edge %0d expected none", tty_char, n);
            end else begin
                p = pq.pop_front();
                if (p.edge_n != n || p.ch != tty_char) begin
                    failures++;
                    $display("FAIL tty: got char %h at edge %0d expected %h at edge %0d",
                             tty_char, n, p.ch, p.edge_n);
                end
            end
        end else if (pq.size() > 0 && pq[0].edge_n <= n) begin
            p = pq.pop_front();
            checks++;
            failures++;
            $display("FAIL tty_missing: got no strobe at edge %0d expected char %h", n, p.ch);
        end

        checks++;
        if (kbd_overrun !== m_ovr) begin
            failures++;
            $display("FAIL kbd_overrun: got %b expected %b at edge %0d", kbd_overrun, m_ovr, n);
        end
    end

    initial begin
        logic [5:0] dev;
        iot_valid = 1'b0; iot_device = '0; iot_func = '0; dataout = '0;
        kbd_strobe = 1'b0; kbd_char = '0;
        resetN = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_skip", skip, 0);
        chk("reset_ac_clear", ac_clear, 0);
        chk("reset_datain_valid", datain_valid, 0);
        chk("reset_datain", datain, 0);
        chk("reset_tty_strobe", tty_strobe, 0);
        chk("reset_tty_char", tty_char, 0);
        chk("reset_kbd_overrun", kbd_overrun, 0);
        resetN = 1'b1;

        kio(F_KSF);
        chk("ksf_after_reset", skip, 0);
        tio(F_TSF, '0);
        chk("tsf_after_reset", skip, 0);

        kstrobe(8'h41);
        kio(F_KSF);
        chk("ksf_flag_set", skip, 1);
        kio(F_KRB);
        chk("krb_datain", datain, 32'h41);
        kio(F_KSF);
        chk("ksf_after_krb", skip, 0);
        idle(2);

        tio(F_TLS, 8'h5A);
        idle(2);
        tio(F_TPC, 8'h77);
        idle(6);
        tio(F_TSF, '0);
        chk("tty_strobe_edge10", tty_strobe, 1);
        chk("tty_char_5a", tty_char, 32'h5A);
        tio(F_TSF, '0);
        chk("tsf_edge11", skip, 1);
        idle(2);

        kstrobe(8'h31);
        kstrobe(8'h32);
`ifdef TTY_KBD_FIFO_EN
        chk("two_strobes_overrun", kbd_overrun, 0);
`else
        chk("two_strobes_overrun", kbd_overrun, 1);
`endif
        kio(F_KRB);
        kio(F_KRB);
        kio(F_KCF);
        kio(F_KCF);
        idle(1);

        kstrobe(8'h31);
        step(1'b1, KDEV, F_KRB, '0, 1'b1, 8'h33);
        chk("krb_with_strobe_datain", datain, 32'h31);
        kio(F_KSF);
        chk("flag_kept_by_strobe", skip, 1);
        kio(F_KRS);
        chk("krs_new_char", datain, 32'h33);
        kio(F_KCF);
        idle(1);

        tio(F_TPC, 8'h99);
        idle(4);
        do_reset();
        idle(PC + 5);
        tio(F_TSF, '0);
        chk("tsf_after_abort", skip, 0);
        chk("overrun_after_reset", kbd_overrun, 0);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0, 3:    dev = KDEV;
                1:       dev = TDEV;
                default: dev = 6'($urandom_range(0, 63));
            endcase
            step($urandom_range(0, 3) != 0, dev, 3'($urandom_range(0, 7)),
                 8'($urandom), $urandom_range(0, 4) == 0, 8'($urandom));
        end
        idle(PC + 4);
        chk("resp_queue_drained", rq.size(), 0);
        chk("tty_queue_drained", pq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
